// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the push-button UART transmitter and the planned
// receiver: line state encoding, frame geometry, default baud divisor and the
// helper that sizes the baud counter.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 10;   // start + 8 data + stop
  localparam int CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200

  // Width needed for a counter running 0..n-1, i.e. ceil(log2(n)), never below 1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Free-running bit-period counter, 0..CLKS_PER_BIT-1, with a synchronous clear.
// Shared between the transmitter and the planned receiver.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clr_i     in   synchronous clear, holds the count at zero
//   cnt_o     out  current count
//   bit_end_o out  high on the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr_i,
  output logic [cnt_width(CLKS_PER_BIT)-1:0]   cnt_o,
  output logic                                 bit_end_o
);

  localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Bit-period counter: wraps at LAST so consecutive bits need no explicit clear.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o     = cnt_q;
  assign bit_end_o = (cnt_q == LAST);

endmodule

// File: rtl/pb_uart_tx.sv
// -----------------------------------------------------------------------------
// pb_uart_tx
// Sends one 8N1 UART frame for every single-cycle request pulse coming from the
// push-button debouncer. One further request can be buffered while a frame is
// on the line; any request beyond that is dropped and flagged as overrun.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   send     in   one-cycle request pulse
//   din      in   byte to transmit, sampled when send=1
//   tx       out  serial line, idle high
//   busy     out  frame in progress or request pending
//   done     out  one-cycle pulse on the last stop-bit cycle
//   overrun  out  sticky, a request was dropped (cleared by rst only)
// -----------------------------------------------------------------------------
module pb_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] din,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
  // One cycle before the bit boundary; lets done be registered yet land on
  // the final stop cycle.
  localparam logic [CNT_W-1:0] NEAR_END = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_W - 1);

  uart_state_e       state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] pend_byte_q;
  logic              pending_q;
  logic [2:0]        bit_idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              overrun_q;

  logic [CNT_W-1:0]  cnt_s;
  logic              bit_end_s;
  logic              cnt_clr_s;

  // Counter is parked at zero while idle, so every frame starts on a clean period.
  assign cnt_clr_s = (state_q == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr_s),
    .cnt_o     (cnt_s),
    .bit_end_o (bit_end_s)
  );

  // Frame FSM with registered line/status outputs and the one-deep request buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      pend_byte_q <= '0;
      pending_q   <= 1'b0;
      bit_idx_q   <= 3'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q <= (state_q == STOP) && (cnt_s == NEAR_END);

      case (state_q)
        IDLE: begin
          bit_idx_q <= 3'd0;
          if (send) begin
            shift_q <= din;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        START: begin
          busy_q <= 1'b1;
          if (bit_end_s) begin
            state_q   <= DATA;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
          end
        end

        DATA: begin
          busy_q <= 1'b1;
          if (bit_end_s) begin
            if (bit_idx_q == LAST_BIT) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              // tx takes the next bit directly since shift_q updates on this edge too
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
        end

        STOP: begin
          busy_q <= 1'b1;
          if (bit_end_s) begin
            // A request arriving exactly now is chained as well: no idle gap.
            if (pending_q || send) begin
              state_q <= START;
              tx_q    <= 1'b0;
              shift_q <= pending_q ? pend_byte_q : din;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= pending_q;
        end
      endcase

      // Request buffering while a frame occupies the line.
      if (state_q != IDLE) begin
        if ((state_q == STOP) && bit_end_s) begin
          // Buffered byte leaves now; a simultaneous request refills the slot.
          if (pending_q) begin
            pending_q <= send;
            if (send) begin
              pend_byte_q <= din;
            end
          end
        end else if (send) begin
          if (pending_q) begin
            overrun_q <= 1'b1;
          end else begin
            pending_q   <= 1'b1;
            pend_byte_q <= din;
          end
        end
      end
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_pb_uart_tx
// Self-checking bench for pb_uart_tx. A timeline model (frame start/end cycle,
// byte on the line, one buffered byte, sticky overrun) predicts tx/busy/done/
// overrun every cycle for a CLKS_PER_BIT=4 instance; directed literal checks pin
// the model. A second CLKS_PER_BIT=868 instance gets directed timing checks.
// -----------------------------------------------------------------------------
module tb_pb_uart_tx;
  import uart_pkg::*;

  localparam int C  = 4;
  localparam int CL = 868;

  logic       clk = 1'b0;
  logic       rst, send;
  logic [7:0] din;
  logic       tx, busy, done, overrun;

  logic       rst_l, send_l;
  logic [7:0] din_l;
  logic       tx_l, busy_l, done_l, overrun_l;

  always #5 clk = ~clk;

  pb_uart_tx #(.CLKS_PER_BIT(C)) u_dut (
    .clk(clk), .rst(rst), .send(send), .din(din),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

  pb_uart_tx #(.CLKS_PER_BIT(CL)) u_dut_long (
    .clk(clk), .rst(rst_l), .send(send_l), .din(din_l),
    .tx(tx_l), .busy(busy_l), .done(done_l), .overrun(overrun_l)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int mt           = 0;   // model cycle index

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, mt, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int         f_start = 0;
  int         f_end   = -1;
  logic [7:0] f_byte  = 8'h00;
  bit         pend_v  = 1'b0;
  logic [7:0] pend_b  = 8'h00;
  bit         ovr     = 1'b0;

  task automatic start_frame(input int t, input logic [7:0] b);
    f_start = t + 1;
    f_end   = t + FRAME_BITS * C;
    f_byte  = b;
  endtask

  always @(negedge clk) begin
    bit   active;
    logic e_tx;
    int   k;
    active = (f_end >= 0) && (mt >= f_start) && (mt <= f_end);
    e_tx   = 1'b1;
    if (active) begin
      k = (mt - f_start) / C;
      if (k == 0)                   e_tx = 1'b0;
      else if (k == FRAME_BITS - 1) e_tx = 1'b1;
      else                          e_tx = f_byte[k-1];
    end
    check("model_tx",      32'(tx),      32'(e_tx));
    check("model_busy",    32'(busy),    32'(active || pend_v));
    check("model_done",    32'(done),    32'(active && (mt == f_end)));
    check("model_overrun", 32'(overrun), 32'(ovr));

    // Apply the inputs sampled at the coming edge.
    if (rst) begin
      f_end  = -1;
      pend_v = 1'b0;
      ovr    = 1'b0;
    end else if (active && (mt == f_end)) begin
      if (pend_v) begin
        start_frame(mt, pend_b);
        if (send) pend_b = din;
        else      pend_v = 1'b0;
      end else if (send) begin
        start_frame(mt, din);
      end
    end else if (active) begin
      if (send) begin
        if (pend_v) ovr = 1'b1;
        else begin
          pend_v = 1'b1;
          pend_b = din;
        end
      end
    end else if (send) begin
      start_frame(mt, din);
    end
    mt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send = 1'b1;
    din  = b;
    tick();
    send = 1'b0;
    din  = 8'($urandom);
  endtask

  task automatic send_byte_l(input logic [7:0] b);
    send_l = 1'b1;
    din_l  = b;
    tick();
    send_l = 1'b0;
    din_l  = 8'($urandom);
  endtask

  logic [9:0] pat_a5 = 10'b1101001010;  // start, A5 LSB first, stop (index 0 first)

  initial begin
    rst = 1'b1; send = 1'b0; din = 8'h00;
    rst_l = 1'b1; send_l = 1'b0; din_l = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    repeat (50) tick();
    @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);

    // Single frame A5, literal waveform.
    tick();
    send_byte(8'hA5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("a5_tx", 32'(tx), 32'(pat_a5[i/4]));
      if (i >= 38) check("a5_done", 32'(done), 32'(i == 39));
    end
    @(negedge clk);
    check("a5_busy_fall", 32'(busy), 32'd0);
    repeat (5) tick();

    // Back-to-back: second request buffered.
    send_byte(8'h3C);
    repeat (9) tick();
    send_byte(8'hC3);
    repeat (69) tick();
    @(negedge clk);
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_busy80", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b_busy81", 32'(busy), 32'd0);
    check("b2b_overrun", 32'(overrun), 32'd0);
    repeat (5) tick();

    // Overrun: third request dropped.
    send_byte(8'h01);
    repeat (4) tick();
    send_byte(8'h02);
    repeat (3) tick();
    send_byte(8'h03);
    @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (100) tick();
    check("ovr_sticky", 32'(overrun), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovr_rst_clear", 32'(overrun), 32'd0);
    repeat (3) tick();

    // Boundary: request on the final stop cycle.
    send_byte(8'h5A);
    repeat (39) tick();
    send_byte(8'h96);
    @(negedge clk);
    check("bnd_start", 32'(tx), 32'd0);
    check("bnd_busy", 32'(busy), 32'd1);
    repeat (60) tick();

    // Boundary with a byte already buffered.
    send_byte(8'h11);
    repeat (9) tick();
    send_byte(8'h22);
    repeat (29) tick();
    send_byte(8'h33);
    repeat (130) tick();
    check("bnd_pend_overrun", 32'(overrun), 32'd0);

    // Reset during data bit 3.
    send_byte(8'hE7);
    repeat (17) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick();
    send_byte(8'h4B);
    repeat (50) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 149) == 0);
      send = ($urandom_range(0, 11) == 0);
      din  = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    send = 1'b0;
    repeat (100) tick();

    // Long divisor: A5 sampled mid-bit.
    rst_l = 1'b0;
    tick();
    send_byte_l(8'hA5);
    check("long_start", 32'(tx_l), 32'd0);
    repeat (433) tick();
    for (int k = 0; k < 10; k++) begin
      check("long_bit", 32'(tx_l), 32'(pat_a5[k]));
      if (k < 9) repeat (868) tick();
    end
    repeat (434) tick();
    check("long_done", 32'(done_l), 32'd1);
    check("long_busy_last", 32'(busy_l), 32'd1);
    tick();
    check("long_done_end", 32'(done_l), 32'd0);
    check("long_busy_fall", 32'(busy_l), 32'd0);

    // Long divisor: reset during data bit 3, then a clean frame.
    send_byte_l(8'hE7);
    repeat (4 * CL + 400) tick();
    rst_l = 1'b1;
    tick();
    rst_l = 1'b0;
    check("long_rst_tx", 32'(tx_l), 32'd1);
    check("long_rst_busy", 32'(busy_l), 32'd0);
    tick();
    send_byte_l(8'h3C);
    check("long2_start", 32'(tx_l), 32'd0);
    repeat (CL + CL / 2) tick();
    check("long2_bit0", 32'(tx_l), 32'd0);
    repeat (CL) tick();
    check("long2_bit1", 32'(tx_l), 32'd0);
    repeat (CL) tick();
    check("long2_bit2", 32'(tx_l), 32'd1);
    check("long2_overrun", 32'(overrun_l), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pb_uart_tx.md
Name: pb_uart_tx

Overview:
- Consumes the single-cycle, clock-enabled pulse from the push-button debouncer and transmits one 8N1 UART frame per pulse.
- The frame carries the data byte presented on din at the moment of the pulse.
- Sits between the debouncer output and the board TX pin.
- Provides one-deep request buffering, so a press during an active frame is not lost, and a sticky overrun flag.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- DATA_W, 8: payload width. Fixed at 8; the parameter exists for documentation and assertions only.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- send  in  1  one-cycle request pulse from the debouncer output
- din  in  8  byte to transmit, sampled on the cycle send=1
- tx  out  1  UART serial line, idle high
- busy  out  1  high while a frame is being shifted or a request is pending
- done  out  1  one-cycle pulse on the last cycle of each stop bit
- overrun  out  1  sticky, set when a request is dropped

Behaviour:
- Reset values (rst=1 at a rising edge):
  - tx=1, busy=0, done=0, overrun=0.
  - pending=0, state=IDLE, bit counter=0, baud counter=0.
  - rst mid-frame aborts the frame; tx=1 from the next edge.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: tx=1. send=1 captures din into the shift register and moves to START on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7 completes, move to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - done=1 on the final STOP cycle only.
    - If pending=1 at that edge: load the pending byte, clear pending, and go straight to START (no idle gap).
    - Otherwise go to IDLE.
- Latency and frame length:
  - tx falls on the first clock after the edge where send was sampled in IDLE.
  - The frame spans exactly 10*CLKS_PER_BIT cycles.
- Baud counter:
  - Runs 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - A bit boundary occurs when the counter equals CLKS_PER_BIT-1.
  - Counter width is ceil(log2(CLKS_PER_BIT)).
- busy is registered:
  - busy=1 whenever state!=IDLE or pending=1.
  - It rises the cycle after the accepted send.
  - It falls on the cycle after done, provided no pending request exists.
- Request while a frame is active:
  - send=1 while state!=IDLE and pending=0: capture din into the pending register and set pending=1.
  - send=1 while pending=1: drop din, set overrun=1. overrun clears only on rst.
  - send=1 on the same edge as final-STOP with pending=0: treated as pending-then-start, so the next frame starts immediately and no pulse is lost.
  - send=1 on the same edge as final-STOP with pending=1: the pending byte goes out and the new byte becomes pending (no overrun).
- send wider than 1 cycle is not expected. Each high cycle counts as a separate request.
- din is ignored except on send cycles.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP}.
  - DATA_BITS=8, FRAME_BITS=10.
  - Default CLKS_PER_BIT=868.
  - A helper function for the counter width.
- Sub-module uart_baud_cnt: CLKS_PER_BIT-cycle counter with synchronous clear input and a bit_end output. It is reused by the planned UART receiver.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset: hold rst 3 cycles, then release with send=0 -> tx=1, busy=0, done=0, overrun=0 for 50 cycles.
- Single frame: send pulse with din=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. tx falls 1 cycle after send. done high exactly 1 cycle at cycle 40. busy low at cycle 41.
- Back-to-back: send 8'h3C, then send 8'hC3 at cycle 10 -> second start bit begins on the cycle after the first done. Total busy span 80 cycles. overrun=0.
- Overrun: send 8'h01, 8'h02, 8'h03 at cycles 0, 5, 9 -> frames 01 and 02 only. overrun=1 from cycle 10 and stays until rst.
- Boundary: send on the exact final-STOP cycle of a frame -> new start bit on the next cycle, no idle gap, byte correct.
- Reset mid-frame: rst during DATA bit 3 -> tx=1 and busy=0 on the next cycle. A fresh send afterwards produces a clean full frame. Repeat with CLKS_PER_BIT=868 for timing sanity.
